// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between the CPU
// and an auxiliary requester; one access in flight, fully registered memory side.
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  output logic              CpuGnt,
  output logic              CpuDone,
  output logic [DATA_W-1:0] CpuRData,
  input  logic              AuxReq,
  input  logic              AuxWe,
  input  logic [ADDR_W-1:0] AuxAddr,
  input  logic [DATA_W-1:0] AuxWData,
  output logic              AuxGnt,
  output logic              AuxDone,
  output logic [DATA_W-1:0] AuxRData,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

  state_t     state;
  logic       last_aux;
  logic       own_aux;
  logic       we_q;
  logic [1:0] cnt;
  logic       pick_aux;

  // Aux wins only if it is the sole requester or the CPU was served last.
  assign pick_aux = AuxReq & (~CpuReq | ~last_aux);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      last_aux <= 1'b1;
      own_aux  <= 1'b0;
      we_q     <= 1'b0;
      cnt      <= 2'd0;
      CpuGnt   <= 1'b0;
      AuxGnt   <= 1'b0;
      CpuDone  <= 1'b0;
      AuxDone  <= 1'b0;
      MemEn    <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      CpuRData <= '0;
      AuxRData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CpuReq | AuxReq) begin
            own_aux  <= pick_aux;
            last_aux <= pick_aux;
            we_q     <= pick_aux ? AuxWe : CpuWe;
            MemAddr  <= pick_aux ? AuxAddr : CpuAddr;
            MemWData <= pick_aux ? AuxWData : CpuWData;
            MemEn    <= 1'b1;
            MemWe    <= pick_aux ? AuxWe : CpuWe;
            CpuGnt   <= ~pick_aux;
            AuxGnt   <= pick_aux;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          MemEn <= 1'b0;
          MemWe <= 1'b0;
          if (we_q) begin
            CpuDone <= ~own_aux;
            AuxDone <= own_aux;
            state   <= DONE;
          end else begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          // Counter hitting zero marks the cycle MemRData is valid.
          if (cnt == 2'd0) begin
            if (own_aux) AuxRData <= MemRData;
            else         CpuRData <= MemRData;
            CpuDone <= ~own_aux;
            AuxDone <= own_aux;
            state   <= DONE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          CpuDone <= 1'b0;
          AuxDone <= 1'b0;
          CpuGnt  <= 1'b0;
          AuxGnt  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiters (READ_LAT=1 and 3) driven by common requests,
// each with its own behavioural RAM that returns a poison word when not read.
module tb_mem_port_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        CpuReq, CpuWe, AuxReq, AuxWe;
  logic [15:0] CpuAddr, CpuWData, AuxAddr, AuxWData;

  logic        CpuGnt, CpuDone, AuxGnt, AuxDone, MemEn, MemWe;
  logic [15:0] CpuRData, AuxRData, MemAddr, MemWData, MemRData;
  logic        CpuGnt3, CpuDone3, AuxGnt3, AuxDone3, MemEn3, MemWe3;
  logic [15:0] CpuRData3, AuxRData3, MemAddr3, MemWData3, MemRData3;

  logic        pl_en;
  logic [15:0] pl_addr, pl_data;
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  logic [15:0] p1;
  logic [15:0] q3 [3];

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) dut1 (
    .Clock(Clock), .Reset(Reset),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuGnt(CpuGnt), .CpuDone(CpuDone), .CpuRData(CpuRData),
    .AuxReq(AuxReq), .AuxWe(AuxWe), .AuxAddr(AuxAddr), .AuxWData(AuxWData),
    .AuxGnt(AuxGnt), .AuxDone(AuxDone), .AuxRData(AuxRData),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData));

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3)) dut3 (
    .Clock(Clock), .Reset(Reset),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuGnt(CpuGnt3), .CpuDone(CpuDone3), .CpuRData(CpuRData3),
    .AuxReq(AuxReq), .AuxWe(AuxWe), .AuxAddr(AuxAddr), .AuxWData(AuxWData),
    .AuxGnt(AuxGnt3), .AuxDone(AuxDone3), .AuxRData(AuxRData3),
    .MemEn(MemEn3), .MemWe(MemWe3), .MemAddr(MemAddr3), .MemWData(MemWData3),
    .MemRData(MemRData3));

  // Behavioural RAMs: read data appears READ_LAT cycles after the MemEn cycle.
  always @(posedge Clock) begin
    if (pl_en) begin
      mem1[pl_addr[7:0]] <= pl_data;
      mem3[pl_addr[7:0]] <= pl_data;
    end
    if (MemEn & MemWe)   mem1[MemAddr[7:0]]  <= MemWData;
    if (MemEn3 & MemWe3) mem3[MemAddr3[7:0]] <= MemWData3;
    p1    <= MemEn  ? mem1[MemAddr[7:0]]  : 16'hDEAD;
    q3[0] <= MemEn3 ? mem3[MemAddr3[7:0]] : 16'hDEAD;
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign MemRData  = p1;
  assign MemRData3 = q3[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    CpuReq = 0; CpuWe = 0; CpuAddr = '0; CpuWData = '0;
    AuxReq = 0; AuxWe = 0; AuxAddr = '0; AuxWData = '0;
    #2;
    reset_dut();
    chk("rst_cpugnt", CpuGnt, 0);
    chk("rst_auxgnt", AuxGnt, 0);
    chk("rst_memen", MemEn, 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_cpurdata", CpuRData, 0);

    // CPU read, READ_LAT=1
    preload(16'h0010, 16'hBEEF);
    preload(16'h00FF, 16'h0000);
    CpuReq = 1; CpuWe = 0; CpuAddr = 16'h0010;
    tick();
    chk("rd_memen_n1", MemEn, 1);
    chk("rd_memwe_n1", MemWe, 0);
    chk("rd_memaddr_n1", MemAddr, 16'h0010);
    chk("rd_cpugnt_n1", CpuGnt, 1);
    chk("rd_auxgnt_n1", AuxGnt, 0);
    tick();
    chk("rd_memen_n2", MemEn, 0);
    chk("rd_done_n2", CpuDone, 0);
    tick();
    chk("rd_done_n3", CpuDone, 1);
    chk("rd_data_n3", CpuRData, 16'hBEEF);
    chk("rd_auxgnt_n3", AuxGnt, 0);
    CpuReq = 0;
    tick();
    chk("rd_gnt_n4", CpuGnt, 0);
    chk("rd_done_n4", CpuDone, 0);

    // Aux write then CPU readback
    AuxReq = 1; AuxWe = 1; AuxAddr = 16'h00FF; AuxWData = 16'h1234;
    tick();
    chk("wr_memen", MemEn, 1);
    chk("wr_memwe", MemWe, 1);
    chk("wr_memaddr", MemAddr, 16'h00FF);
    chk("wr_memwdata", MemWData, 16'h1234);
    chk("wr_auxgnt", AuxGnt, 1);
    tick();
    chk("wr_auxdone", AuxDone, 1);
    chk("wr_memwe_n2", MemWe, 0);
    AuxReq = 0; AuxWe = 0;
    tick();
    chk("wr_auxdone_n3", AuxDone, 0);
    CpuReq = 1; CpuAddr = 16'h00FF;
    tick(); tick(); tick();
    chk("rb_done", CpuDone, 1);
    chk("rb_data", CpuRData, 16'h1234);
    chk("rb_auxrdata", AuxRData, 0);
    CpuReq = 0;
    repeat (6) tick();

    // Both reading continuously: strict alternation, period 4
    CpuReq = 1; CpuAddr = 16'h0010; AuxReq = 1; AuxWe = 0; AuxAddr = 16'h00FF;
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      int ph;
      ph = i % 8;
      chk("rr_cpugnt", CpuGnt, (ph >= 1 && ph <= 3) ? 1 : 0);
      chk("rr_auxgnt", AuxGnt, (ph >= 5) ? 1 : 0);
      chk("rr_cpudone", CpuDone, (ph == 3) ? 1 : 0);
      chk("rr_auxdone", AuxDone, (ph == 7) ? 1 : 0);
      chk("rr_memen", MemEn, (i % 4 == 1) ? 1 : 0);
      if (ph == 3) chk("rr_cpudata", CpuRData, 16'hBEEF);
      if (ph == 7) chk("rr_auxdata", AuxRData, 16'h1234);
      tick();
    end
    CpuReq = 0; AuxReq = 0;
    repeat (8) tick();

    // READ_LAT=3 CPU read
    reset_dut();
    preload(16'h0002, 16'h5A5A);
    CpuReq = 1; CpuAddr = 16'h0002;
    tick();
    chk("l3_memen_n1", MemEn3, 1);
    tick();
    chk("l3_memen_n2", MemEn3, 0);
    chk("l3_rdata_n2", CpuRData3, 0);
    tick(); tick();
    chk("l3_done_n4", CpuDone3, 0);
    chk("l3_rdata_n4", CpuRData3, 0);
    chk("l3_memen_n4", MemEn3, 0);
    tick();
    chk("l3_done_n5", CpuDone3, 1);
    chk("l3_rdata_n5", CpuRData3, 16'h5A5A);
    CpuReq = 0;
    tick();
    chk("l3_done_n6", CpuDone3, 0);
    chk("l3_gnt_n6", CpuGnt3, 0);
    repeat (8) tick();

    // Inputs changed after grant are ignored
    preload(16'h0030, 16'hC0DE);
    preload(16'h0777, 16'h7777);
    CpuReq = 1; CpuAddr = 16'h0030;
    tick();
    chk("lat_addr_n1", MemAddr, 16'h0030);
    CpuAddr = 16'h0777; CpuReq = 0;
    tick();
    chk("lat_addr_n2", MemAddr, 16'h0030);
    chk("lat_gnt_n2", CpuGnt, 1);
    tick();
    chk("lat_done", CpuDone, 1);
    chk("lat_data", CpuRData, 16'hC0DE);
    repeat (8) tick();

    // Reset in WAIT abandons the CPU read; CPU then wins the tie again
    CpuReq = 1; CpuAddr = 16'h0010;
    tick(); tick();
    Reset = 1;
    tick();
    Reset = 0;
    chk("wr_rst_cpugnt", CpuGnt, 0);
    chk("wr_rst_cpudone", CpuDone, 0);
    chk("wr_rst_memen", MemEn, 0);
    chk("wr_rst_memaddr", MemAddr, 0);
    chk("wr_rst_rdata", CpuRData, 0);
    AuxReq = 1; AuxWe = 0; AuxAddr = 16'h00FF;
    tick();
    chk("post_cpugnt", CpuGnt, 1);
    chk("post_auxgnt", AuxGnt, 0);
    tick(); tick();
    chk("post_cpudone", CpuDone, 1);
    chk("post_auxdone", AuxDone, 0);
    chk("post_data", CpuRData, 16'hBEEF);
    CpuReq = 0; AuxReq = 0;
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
